// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory bus between two requesters and sequences the ar/ce/we/t3 strobes
// Optional MEM_ARB_RR_EN: round-robin arbitration on ties (default build: fixed priority, port 0 first)
module mem_bus_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RAM_BIT = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] ar,
    output logic          ce,
    output logic          we,
    output logic          t3,
    inout  wire  [DW-1:0] bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STRB, RD2, DONE} state_t;
    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ar;
    logic [DW-1:0] r_wreg;
    logic [DW-1:0] r_rdata;
    logic          r_we;
    logic          r_owner;
    logic          w_any;
    logic          w_win1;
    logic          w_rom_wr;
    logic          w_busy;
    assign w_any    = req0 || req1;
    assign w_rom_wr = r_we && !r_ar[RAM_BIT];
`ifdef MEM_ARB_RR_EN
    logic r_last;
    assign w_win1 = req1 && (!req0 || !r_last);
    // remember which port was served last so the other one wins the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= 1'b1;
        else if (r_state == IDLE && w_any)
            r_last <= w_win1;
    end
`else
    assign w_win1 = req1 && !req0;
`endif
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // access sequencing: ROM writes skip the strobe, reads hold the strobe one extra cycle
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_any ? SETUP : IDLE;
            SETUP:   w_next = w_rom_wr ? DONE : STRB;
            STRB:    w_next = r_we ? DONE : RD2;
            RD2:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    // latch the winner's request on grant and capture read data at the end of RD2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar    <= '0;
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_owner <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_ar    <= w_win1 ? addr1 : addr0;
                r_we    <= w_win1 ? we1 : we0;
                r_wreg  <= w_win1 ? wdata1 : wdata0;
                r_owner <= w_win1;
            end
            if (r_state == RD2)
                r_rdata <= bus;
        end
    end
    assign w_busy = r_state != IDLE;
    assign ce     = r_state == SETUP || r_state == STRB || r_state == RD2;
    assign t3     = r_state == STRB || r_state == RD2;
    assign we     = ce && r_we;
    assign ar     = r_ar;
    assign rdata  = r_rdata;
    assign gnt0   = w_busy && !r_owner;
    assign gnt1   = w_busy && r_owner;
    assign done0  = r_state == DONE && !r_owner;
    assign done1  = r_state == DONE && r_owner;
    assign err    = r_state == DONE && w_rom_wr;
    assign bus    = (we && (r_state == SETUP || r_state == STRB)) ? r_wreg : 'z;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random accesses against a memory model and a reference memory image
module tb_mem_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       gnt0, gnt1, done0, done1, err, ce, we, t3;
    logic [7:0] rdata, ar;
    wire  [7:0] bus;
    logic [7:0] rom [128];
    logic [7:0] ram [128];
    logic [7:0] ref_mem [256];
    logic       ram_clr = 1'b1;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .err(err), .ar(ar), .ce(ce), .we(we), .t3(t3), .bus(bus)
    );

    function automatic logic [7:0] rom_val(input int i);
        return (i == 16) ? 8'hA7 : 8'(i * 37 + 91);
    endfunction

    assign bus = (ce && !we && t3) ? (ar[7] ? ram[ar[6:0]] : rom[ar[6:0]]) : 8'hzz;

    always @(posedge clk) begin
        if (ram_clr)
            for (int i = 0; i < 128; i++) ram[i] <= 8'h00;
        else if (ce && we && t3 && ar[7])
            ram[ar[6:0]] <= bus;
    end

    initial for (int i = 0; i < 128; i++) rom[i] = rom_val(i);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic release_req(input int p);
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic access(input int p, input logic w, input logic [7:0] a, input logic [7:0] d, input int drop_at);
        int   n, strobes, exp_n, exp_strobes;
        logic rom_wr, got;
        rom_wr      = w && !a[7];
        exp_n       = rom_wr ? 2 : (w ? 3 : 4);
        exp_strobes = rom_wr ? 0 : (w ? 1 : 2);
        drive(p, w, a, d);
        n = 0;
        strobes = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (n == drop_at) release_req(p);
            if (n == 1) begin
                chk("grant", p ? gnt1 : gnt0, 1);
                chk("other_gnt", p ? gnt0 : gnt1, 0);
                chk("ar", ar, a);
                chk("ce_setup", ce, 1);
            end
            if (t3) begin
                strobes++;
                if (w) chk("bus_wdata", bus, d);
            end
            if (ce && !w) chk("we_read", we, 0);
            got = p ? done1 : done0;
        end
        release_req(p);
        chk("done_latency", n, exp_n);
        chk("t3_cycles", strobes, exp_strobes);
        chk("err", err, rom_wr);
        chk("ce_done", ce, 0);
        chk("other_done", p ? done0 : done1, 0);
        if (w && a[7]) ref_mem[a] = d;
        if (!w) chk("rdata", rdata, ref_mem[a]);
        @(posedge clk);
        #1;
        chk("idle_gnt", {gnt0, gnt1}, 0);
    endtask

    initial begin
        int   n;
        logic last, exp_w;
        for (int i = 0; i < 256; i++) ref_mem[i] = (i < 128) ? rom_val(i) : 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ar", ar, 0);
        chk("rst_strobes", {ce, we, t3}, 0);
        chk("rst_gnt_done", {gnt0, gnt1, done0, done1, err}, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        ram_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_no_req", {gnt0, gnt1}, 0);

        access(1, 1'b1, 8'h85, 8'h3C, 0);
        access(0, 1'b0, 8'h85, 8'h00, 0);
        access(0, 1'b0, 8'h10, 8'h00, 0);
        access(0, 1'b1, 8'h20, 8'h55, 0);
        access(1, 1'b0, 8'h20, 8'h00, 0);

        last = 1'b1;
        drive(0, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b0, 8'h11, 8'h00);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(gnt0 || gnt1) && n < 10) begin @(posedge clk); #1; n++; end
`ifdef MEM_ARB_RR_EN
            exp_w = !last;
`else
            exp_w = 1'b0;
`endif
            chk("tie_winner", gnt1, exp_w);
            chk("tie_onehot", gnt0 ^ gnt1, 1);
            last = exp_w;
            n = 0;
            while (!(done0 || done1) && n < 10) begin @(posedge clk); #1; n++; end
            chk("tie_done_port", done1, exp_w);
            chk("tie_done_ce", ce, 0);
            chk("tie_rdata", rdata, ref_mem[exp_w ? 8'h11 : 8'h10]);
            @(posedge clk);
            #1;
            chk("tie_gap", gnt0 | gnt1, 0);
        end
        release_req(0);
        release_req(1);
        @(posedge clk);
        #1;

        drive(0, 1'b0, 8'h10, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rd2_reached", {ce, t3, gnt0}, 3'b111);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {ce, we, t3}, 0);
        chk("rst_mid_gnt_done", {gnt0, gnt1, done0, done1}, 0);
        release_req(0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_no_done", {done0, done1}, 0);
        @(posedge clk);
        #1;
        access(0, 1'b0, 8'h10, 8'h00, 0);

        access(0, 1'b1, 8'h90, 8'h6E, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_req_no_grant", {gnt0, gnt1, ce}, 0);
        end
        access(1, 1'b0, 8'h90, 8'h00, 0);

        for (int k = 0; k < 24; k++)
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
